masku_cmp_seq: RTL
==================

MASKU_CMP_SEQ -- requirements
Module: masku_cmp_seq

Interface
REQ-001 SHALL have parameter NrLanes, default 4: number of lanes; DATAPATH_WIDTH = NrLanes*ELEN (ELEN = 64).
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start_valid_i, input, 1: a new compare instruction is offered.
REQ-005 SHALL have port start_ready_o, output, 1: the sequencer accepts an instruction.
REQ-006 SHALL have port vl_i, input, vlen_t: element count of the offered instruction.
REQ-007 SHALL have port vsew_i, input, vew_e: source SEW of the offered instruction.
REQ-008 SHALL have port op_valid_i, input, NrLanes: per-lane ALU/FPU compare result valid.
REQ-009 SHALL have port op_ready_o, output, NrLanes: per-lane operand consume.
REQ-010 SHALL have port vrf_pnt_o, output, idx_width(DATAPATH_WIDTH)+1: bit offset in the mask word where the current beat is compressed.
REQ-011 SHALL have port compress_en_o, output, 1: the accumulator ORs the compressed beat at vrf_pnt_o this cycle.
REQ-012 SHALL have port acc_clear_o, output, 1: the accumulator clears on the next edge.
REQ-013 SHALL have port result_valid_o, output, 1: the accumulated mask word is ready for write-back.
REQ-014 SHALL have port result_ready_i, input, 1: write-back accepted.
REQ-015 SHALL have port result_last_o, output, 1: the current result word is the final word of the instruction.
REQ-016 SHALL have port busy_o, output, 1: state is not IDLE.
REQ-017 SHALL have port done_o, output, 1: one-cycle pulse when the instruction completes.

Function
REQ-018 SHALL define EPB (elements per beat) = NrLanes*(8>>vsew), computed from the latched vsew.
REQ-019 SHALL implement FSM states IDLE, COLLECT and WRITE.
REQ-020 SHALL drive start_ready_o=1 only in IDLE.
  - On start handshake: latch vl and vsew, set remaining=vl and pnt=0.
  - Next state is COLLECT if vl>0.
  - If vl==0: stay in IDLE, pulse done_o on the next cycle, emit no result.
REQ-021 In COLLECT, a beat SHALL fire only when &op_valid_i=1.
  - op_ready_o = all-ones on a beat cycle, all-zeros otherwise.
  - Partial lane validity consumes nothing.
REQ-022 On a beat, compress_en_o SHALL be 1 in the same cycle, with vrf_pnt_o equal to the pre-beat pnt.
  - Next cycle: pnt += EPB.
  - Next cycle: remaining -= min(EPB, remaining).
REQ-023 After a beat, state SHALL go to WRITE if pnt+EPB == DATAPATH_WIDTH (word full) or remaining <= EPB (last beat); otherwise it stays in COLLECT.
REQ-024 In WRITE, result_valid_o SHALL be 1, op_ready_o SHALL be 0, and result_last_o SHALL equal (remaining==0).
REQ-025 On result handshake, acc_clear_o SHALL pulse in the same cycle and pnt SHALL reset to 0.
  - If remaining==0: next state IDLE, done_o pulses next cycle.
  - Otherwise: next state COLLECT.
REQ-026 With result_ready_i low, WRITE SHALL hold indefinitely with all outputs stable.
REQ-027 pnt SHALL never exceed DATAPATH_WIDTH; remaining SHALL saturate at 0 and never wrap.
REQ-028 start_valid_i outside IDLE SHALL be ignored; no instruction is accepted in the cycle done_o pulses from WRITE (state is IDLE only from the next cycle).
REQ-029 compress_en_o, acc_clear_o, result_valid_o and done_o SHALL never be asserted outside their states above.

Reset
REQ-030 Asserting rst_ni low SHALL set, immediately and regardless of state:
  - state=IDLE, pnt=0, remaining=0;
  - all outputs 0 except start_ready_o (deasserted while in reset, 1 after release).
REQ-031 Reset mid-instruction SHALL abandon the instruction with no result_valid_o or done_o; the accumulator is cleared by its own reset.

Verification (NrLanes=4)
REQ-032 vl=10, EW8 -> one beat at pnt=0 (EPB=32); WRITE with result_last_o=1; done_o one cycle after the handshake.
REQ-033 vl=300, EW8 -> 8 beats at pnt=0,32,...,224; then non-last WRITE; 2 beats at pnt=0,32; then last WRITE; acc_clear_o on each handshake.
REQ-034 vl=256, EW64 (EPB=4) -> 64 beats with pnt stepping by 4 to 252; exactly one WRITE, last=1.
REQ-035 op_valid_i=4'b0111 for 5 cycles, then 4'b1111 -> op_ready_o=0 for 5 cycles, one beat on the sixth; result_ready_i low 3 cycles in WRITE -> outputs held, no beat.
REQ-036 rst_ni low during COLLECT after 3 beats -> state IDLE, vrf_pnt_o=0, no done_o; a new start after release proceeds normally; vl=0 start -> done_o pulse, no result_valid_o.

Source files
------------

// File: rtl/masku_cmp_seq_if.sv
// Handshake and datapath-control bundle between the mask-unit compare sequencer
// and its surroundings (instruction issue, lane operands, accumulator, write-back).
interface masku_cmp_seq_if #(
   parameter int unsigned NrLanes = 4,
   parameter int unsigned VlW     = 16
);
   localparam int unsigned PntW = $clog2(NrLanes * 64) + 1;

   logic                start_valid_i;
   logic                start_ready_o;
   logic [VlW-1:0]      vl_i;
   logic [1:0]          vsew_i;
   logic [NrLanes-1:0]  op_valid_i;
   logic [NrLanes-1:0]  op_ready_o;
   logic [PntW-1:0]     vrf_pnt_o;
   logic                compress_en_o;
   logic                acc_clear_o;
   logic                result_valid_o;
   logic                result_ready_i;
   logic                result_last_o;
   logic                busy_o;
   logic                done_o;

   modport master (
      output start_valid_i, vl_i, vsew_i, op_valid_i, result_ready_i,
      input  start_ready_o, op_ready_o, vrf_pnt_o, compress_en_o, acc_clear_o,
             result_valid_o, result_last_o, busy_o, done_o
   );

   modport slave (
      input  start_valid_i, vl_i, vsew_i, op_valid_i, result_ready_i,
      output start_ready_o, op_ready_o, vrf_pnt_o, compress_en_o, acc_clear_o,
             result_valid_o, result_last_o, busy_o, done_o
   );
endinterface

// File: rtl/masku_cmp_seq.sv
// Mask-unit compare sequencer: gathers per-lane compare beats into a
// DATAPATH_WIDTH-bit mask word and hands each word to write-back.
module masku_cmp_seq #(
   parameter int unsigned NrLanes = 4,
   parameter int unsigned VlW     = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   masku_cmp_seq_if.slave bus
);
   localparam int unsigned ELEN           = 64;
   localparam int unsigned DATAPATH_WIDTH = NrLanes * ELEN;
   localparam int unsigned PntW           = $clog2(DATAPATH_WIDTH) + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] WRITE   = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [PntW-1:0] pnt_q, pnt_d;
   logic [VlW-1:0] remaining_q, remaining_d;
   logic [1:0]     vsew_q, vsew_d;
   logic           done_q, done_d;

   logic [31:0]     epb;
   logic [PntW-1:0] pnt_next;
   logic [VlW-1:0]  rem_step;
   logic            last_beat;
   logic            word_full;
   logic            start_ready;
   logic            beat;
   logic            wb_hs;

   assign epb       = NrLanes * (32'd8 >> vsew_q);
   assign pnt_next  = pnt_q + PntW'(epb);
   assign last_beat = 32'(remaining_q) <= epb;
   assign rem_step  = last_beat ? remaining_q : VlW'(epb);
   assign word_full = pnt_next == PntW'(DATAPATH_WIDTH);

   // The done cycle after a write-back still refuses new work.
   assign start_ready = rst_ni && (state_q == IDLE) && !done_q;
   assign beat        = (state_q == COLLECT) && (&bus.op_valid_i);
   assign wb_hs       = (state_q == WRITE) && bus.result_ready_i;

   always_comb begin
      state_d     = state_q;
      pnt_d       = pnt_q;
      remaining_d = remaining_q;
      vsew_d      = vsew_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_valid_i && start_ready) begin
               vsew_d      = bus.vsew_i;
               remaining_d = bus.vl_i;
               pnt_d       = '0;
               if (bus.vl_i == '0) done_d = 1'b1;
               else                state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (beat) begin
               pnt_d       = pnt_next;
               remaining_d = remaining_q - rem_step;
               if (word_full || last_beat) state_d = WRITE;
            end
         end
         WRITE: begin
            if (bus.result_ready_i) begin
               pnt_d = '0;
               if (remaining_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = COLLECT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pnt_q       <= '0;
         remaining_q <= '0;
         vsew_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pnt_q       <= pnt_d;
         remaining_q <= remaining_d;
         vsew_q      <= vsew_d;
         done_q      <= done_d;
      end
   end

   assign bus.start_ready_o  = start_ready;
   assign bus.op_ready_o     = {NrLanes{beat}};
   assign bus.vrf_pnt_o      = pnt_q;
   assign bus.compress_en_o  = beat;
   assign bus.acc_clear_o    = wb_hs;
   assign bus.result_valid_o = state_q == WRITE;
   assign bus.result_last_o  = (state_q == WRITE) && (remaining_q == '0);
   assign bus.busy_o         = state_q != IDLE;
   assign bus.done_o         = done_q;
endmodule
